lsu_mem_ctrl: RTL and testbench

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

---
 rtl/lsu_mem_ctrl_if.sv | 55 +++++
 rtl/lsu_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Handshake bundles for the load/store memory controller: upstream request/response
// channel (lsu_req_if) and the downstream memory command/completion bus (lsu_mem_bus_if).
interface lsu_req_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wen;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic [1:0]        resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_bus_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    localparam int NB = XLEN / 8;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_wdata;
    logic [NB-1:0]     mem_wstrb;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_err;

    modport master (
        output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_ready, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store unit memory controller: alignment check, byte-lane
// steering, load extension and a command/wait timeout, with registered bus outputs.
module lsu_mem_ctrl #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input logic           clock,
    input logic           reset,
    lsu_req_if.slave      req,
    lsu_mem_bus_if.master mem
);
    localparam int NB    = XLEN / 8;
    localparam int OFS_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    state_t           state;
    logic [OFS_W-1:0] ofs_q;
    logic [1:0]       size_q;
    logic             wen_q;
    logic             unsigned_q;
    logic [15:0]      tmo_cnt;

    logic [OFS_W-1:0] req_ofs;
    logic             misaligned;
    logic [NB-1:0]    req_strb;
    logic [XLEN-1:0]  load_shift;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  resp_data_next;
    logic [1:0]       resp_err_next;
    logic             sign_bit;
    logic             tmo_hit;
    int               load_bits;

    assign req.req_ready = (state == IDLE);
    assign tmo_hit       = (tmo_cnt == 16'(TIMEOUT - 1));

    // A doubleword on a 32-bit datapath can never be aligned, so it is rejected outright.
    always_comb begin
        req_ofs    = req.req_addr[OFS_W-1:0];
        misaligned = 1'b0;
        req_strb   = '0;
        case (req.req_size)
            2'd0: begin
                misaligned = 1'b0;
                req_strb   = NB'(1);
            end
            2'd1: begin
                misaligned = req_ofs[0];
                req_strb   = NB'(3);
            end
            2'd2: begin
                misaligned = (req_ofs[1:0] != 2'b00);
                req_strb   = NB'(15);
            end
            default: begin
                misaligned = (XLEN == 32) || (req_ofs != '0);
                req_strb   = '1;
            end
        endcase
        req_strb = req_strb << req_ofs;
    end

    always_comb begin
        load_shift = mem.mem_rdata >> {ofs_q, 3'b000};
        load_bits  = 8 << size_q;
        case (size_q)
            2'd0:    sign_bit = load_shift[7];
            2'd1:    sign_bit = load_shift[15];
            2'd2:    sign_bit = load_shift[31];
            default: sign_bit = load_shift[XLEN-1];
        endcase
        load_data = load_shift;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= load_bits) begin
                load_data[i] = ~unsigned_q & sign_bit;
            end
        end
        resp_data_next = (mem.mem_err || wen_q) ? '0 : load_data;
        resp_err_next  = mem.mem_err ? 2'd2 : 2'd0;
    end

    // Completion has priority over the timeout in the same cycle; a timed-out command
    // drops mem_valid and any straggling completion is ignored outside CMD/WAIT.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            ofs_q          <= '0;
            size_q         <= 2'd0;
            wen_q          <= 1'b0;
            unsigned_q     <= 1'b0;
            tmo_cnt        <= '0;
            mem.mem_valid  <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wen    <= 1'b0;
            mem.mem_wdata  <= '0;
            mem.mem_wstrb  <= '0;
            req.resp_valid <= 1'b0;
            req.resp_rdata <= '0;
            req.resp_err   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        ofs_q      <= req_ofs;
                        size_q     <= req.req_size;
                        wen_q      <= req.req_wen;
                        unsigned_q <= req.req_unsigned;
                        if (misaligned) begin
                            req.resp_valid <= 1'b1;
                            req.resp_rdata <= '0;
                            req.resp_err   <= 2'd1;
                            state          <= RESP;
                        end else begin
                            mem.mem_valid <= 1'b1;
                            mem.mem_addr  <= {req.req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                            mem.mem_wen   <= req.req_wen;
                            mem.mem_wdata <= req.req_wen ? (req.req_wdata << {req_ofs, 3'b000}) : '0;
                            mem.mem_wstrb <= req.req_wen ? req_strb : '0;
                            tmo_cnt       <= '0;
                            state         <= CMD;
                        end
                    end
                end
                CMD: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (mem.mem_ready && mem.mem_rvalid) begin
                        mem.mem_valid  <= 1'b0;
                        req.resp_valid <= 1'b1;
                        req.resp_rdata <= resp_data_next;
                        req.resp_err   <= resp_err_next;
                        state          <= RESP;
                    end else if (tmo_hit) begin
                        mem.mem_valid  <= 1'b0;
                        req.resp_valid <= 1'b1;
                        req.resp_rdata <= '0;
                        req.resp_err   <= 2'd3;
                        state          <= RESP;
                    end else if (mem.mem_ready) begin
                        mem.mem_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (mem.mem_rvalid) begin
                        req.resp_valid <= 1'b1;
                        req.resp_rdata <= resp_data_next;
                        req.resp_err   <= resp_err_next;
                        state          <= RESP;
                    end else if (tmo_hit) begin
                        req.resp_valid <= 1'b1;
                        req.resp_rdata <= '0;
                        req.resp_err   <= 2'd3;
                        state          <= RESP;
                    end
                end
                default: begin
                    if (req.resp_ready) begin
                        req.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl (XLEN=64, TIMEOUT=4) against a
// byte-array memory reference model and a responsive memory slave.
module tb_lsu_mem_ctrl;
    logic clock;
    logic reset;

    lsu_req_if     #(.XLEN(64), .ADDR_W(64)) rif ();
    lsu_mem_bus_if #(.XLEN(64), .ADDR_W(64)) mif ();

    lsu_mem_ctrl #(.XLEN(64), .ADDR_W(64), .TIMEOUT(4)) dut (
        .clock (clock),
        .reset (reset),
        .req   (rif.slave),
        .mem   (mif.master)
    );

    logic [7:0]  ref_mem   [64];
    logic [7:0]  slave_mem [64];
    int          n_checks;
    int          n_pass;
    int          n_fail;
    logic [63:0] last_cmd_addr;
    logic [63:0] last_cmd_wdata;
    logic [7:0]  last_cmd_strb;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Little-endian read of the reference bytes, then sign/zero extension to 64 bits.
    function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [1:0] size, input logic uns);
        int nbytes;
        logic [63:0] v;
        nbytes = 1 << size;
        v = '0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[int'(addr[5:0]) + i];
        if (!uns && v[8*nbytes-1]) begin
            for (int i = 8 * nbytes; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [63:0] slave_word(input logic [63:0] addr);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = slave_mem[{addr[5:3], 3'(i)}];
        return w;
    endfunction

    task automatic apply_stimulus(
        input  logic [63:0] addr,
        input  logic        wen,
        input  logic [1:0]  size,
        input  logic        uns,
        input  logic [63:0] wdata,
        input  int          ready_dly,
        input  int          rvalid_dly,
        input  logic        no_rvalid,
        input  logic        err_inj,
        input  int          resp_dly,
        output logic [63:0] got_rdata,
        output logic [1:0]  got_err
    );
        logic        mis, timed_out, hs_done, done, saw_cmd;
        logic [1:0]  exp_err;
        logic [63:0] exp_rdata, exp_wdata;
        logic [7:0]  exp_strb;
        int          exp_lat, lat, cmd_n, age;

        mis       = (addr % (64'd1 << size)) != 64'd0;
        timed_out = no_rvalid || (ready_dly + 1 + rvalid_dly > 4);
        exp_strb  = '0;
        if (!mis) begin
            for (int i = 0; i < (1 << size); i++) exp_strb[int'(addr[2:0]) + i] = 1'b1;
        end
        exp_wdata = wdata << (8 * int'(addr[2:0]));
        exp_rdata = '0;
        if (mis) begin
            exp_err = 2'd1;
            exp_lat = 0;
        end else if (timed_out) begin
            exp_err = 2'd3;
            exp_lat = 4;
        end else begin
            exp_err = err_inj ? 2'd2 : 2'd0;
            exp_lat = ready_dly + 1 + rvalid_dly;
            if (!err_inj && !wen) exp_rdata = model_load(addr, size, uns);
        end

        @(negedge clock);
        check_output("req_ready_idle", 64'(rif.req_ready), 64'd1);
        rif.req_valid    = 1'b1;
        rif.req_addr     = addr;
        rif.req_wen      = wen;
        rif.req_size     = size;
        rif.req_unsigned = uns;
        rif.req_wdata    = wdata;
        @(negedge clock);
        rif.req_valid = 1'b0;
        rif.req_wdata = {$urandom, $urandom};
        if (mis) check_output("misaligned_no_mem_valid", 64'(mif.mem_valid), 64'd0);

        lat = 0; cmd_n = 0; age = 0; hs_done = 0; done = 0; saw_cmd = 0;
        while (!rif.resp_valid && lat < 20) begin
            mif.mem_ready  = 1'b0;
            mif.mem_rvalid = 1'b0;
            mif.mem_err    = 1'b0;
            mif.mem_rdata  = {$urandom, $urandom};
            if (mif.mem_valid && !hs_done) begin
                if (!saw_cmd) begin
                    saw_cmd        = 1'b1;
                    last_cmd_addr  = mif.mem_addr;
                    last_cmd_wdata = mif.mem_wdata;
                    last_cmd_strb  = mif.mem_wstrb;
                    check_output("mem_addr", mif.mem_addr, addr & ~64'h7);
                    check_output("mem_wen", 64'(mif.mem_wen), 64'(wen));
                    check_output("mem_wstrb", 64'(mif.mem_wstrb), wen ? 64'(exp_strb) : 64'd0);
                    if (wen) check_output("mem_wdata", mif.mem_wdata, exp_wdata);
                end else begin
                    check_output("mem_addr_hold", mif.mem_addr, last_cmd_addr);
                end
                if (cmd_n == ready_dly) begin
                    mif.mem_ready = 1'b1;
                    hs_done = 1'b1;
                end
                cmd_n++;
            end else if (hs_done) begin
                age++;
            end
            if (hs_done && !done && !no_rvalid && age == rvalid_dly) begin
                mif.mem_rvalid = 1'b1;
                mif.mem_err    = err_inj;
                mif.mem_rdata  = wen ? {$urandom, $urandom} : slave_word(last_cmd_addr);
                done = 1'b1;
                if (wen && !err_inj) begin
                    for (int i = 0; i < 8; i++)
                        if (last_cmd_strb[i]) slave_mem[{last_cmd_addr[5:3], 3'(i)}] = last_cmd_wdata[8*i +: 8];
                end
            end
            lat++;
            @(negedge clock);
        end
        mif.mem_ready  = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_err    = 1'b0;

        check_output("resp_valid", 64'(rif.resp_valid), 64'd1);
        check_output("resp_latency", 64'(lat), 64'(exp_lat));
        check_output("mem_cmd_seen", 64'(saw_cmd), 64'(!mis));
        got_rdata = rif.resp_rdata;
        got_err   = rif.resp_err;
        check_output("resp_rdata", got_rdata, exp_rdata);
        check_output("resp_err", 64'(got_err), 64'(exp_err));

        for (int k = 0; k < resp_dly; k++) begin
            rif.resp_ready = 1'b0;
            if (no_rvalid) begin
                mif.mem_rvalid = 1'b1;
                mif.mem_err    = 1'b1;
                mif.mem_rdata  = {$urandom, $urandom};
            end
            @(negedge clock);
            check_output("hold_resp_valid", 64'(rif.resp_valid), 64'd1);
            check_output("hold_resp_rdata", rif.resp_rdata, exp_rdata);
            check_output("hold_resp_err", 64'(rif.resp_err), 64'(exp_err));
            check_output("hold_req_ready", 64'(rif.req_ready), 64'd0);
            check_output("hold_mem_valid", 64'(mif.mem_valid), 64'd0);
        end
        mif.mem_rvalid = 1'b0;
        mif.mem_err    = 1'b0;
        rif.resp_ready = 1'b1;
        @(negedge clock);
        rif.resp_ready = 1'b0;
        check_output("resp_valid_cleared", 64'(rif.resp_valid), 64'd0);
        check_output("req_ready_after_resp", 64'(rif.req_ready), 64'd1);

        if (!mis && !timed_out && !err_inj && wen) begin
            for (int i = 0; i < (1 << size); i++) ref_mem[int'(addr[5:0]) + i] = wdata[8*i +: 8];
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] a, wd, rd;
        logic [1:0]  sz, er;
        logic        we, un, nr, ei;
        logic [7:0]  b;

        n_checks = 0; n_pass = 0; n_fail = 0;
        reset = 1'b0;
        rif.req_valid = 1'b0; rif.req_addr = '0; rif.req_wen = 1'b0; rif.req_size = 2'd0;
        rif.req_unsigned = 1'b0; rif.req_wdata = '0; rif.resp_ready = 1'b0;
        mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0; mif.mem_err = 1'b0;
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom);
            ref_mem[i] = b;
            slave_mem[i] = b;
        end

        repeat (3) @(negedge clock);
        check_output("rst_resp_valid", 64'(rif.resp_valid), 64'd0);
        check_output("rst_mem_valid", 64'(mif.mem_valid), 64'd0);
        check_output("rst_mem_wen", 64'(mif.mem_wen), 64'd0);
        check_output("rst_mem_wstrb", 64'(mif.mem_wstrb), 64'd0);
        check_output("rst_resp_rdata", rif.resp_rdata, 64'd0);
        check_output("rst_resp_err", 64'(rif.resp_err), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check_output("rst_release_req_ready", 64'(rif.req_ready), 64'd1);

        // Signed byte load of 0x80 at offset 3, response held off for 5 cycles.
        ref_mem[3] = 8'h80;
        slave_mem[3] = 8'h80;
        apply_stimulus(64'h1003, 1'b0, 2'd0, 1'b0, 64'd0, 0, 1, 1'b0, 1'b0, 5, rd, er);
        check_output("signed_byte_rdata", rd, 64'hFFFF_FFFF_FFFF_FF80);
        check_output("signed_byte_err", 64'(er), 64'd0);

        apply_stimulus(64'h1004, 1'b1, 2'd2, 1'b0, 64'hDEAD_BEEF, 1, 1, 1'b0, 1'b0, 0, rd, er);
        check_output("store_word_addr", last_cmd_addr, 64'h1000);
        check_output("store_word_strb", 64'(last_cmd_strb), 64'hF0);
        check_output("store_word_wdata", last_cmd_wdata, 64'hDEAD_BEEF_0000_0000);
        apply_stimulus(64'h1004, 1'b0, 2'd2, 1'b1, 64'd0, 0, 0, 1'b0, 1'b0, 1, rd, er);
        check_output("store_word_readback", rd, 64'hDEAD_BEEF);

        apply_stimulus(64'h1002, 1'b0, 2'd2, 1'b0, 64'd0, 0, 0, 1'b0, 1'b0, 0, rd, er);
        check_output("misaligned_err", 64'(er), 64'd1);

        apply_stimulus(64'h1010, 1'b0, 2'd3, 1'b0, 64'd0, 0, 0, 1'b1, 1'b0, 2, rd, er);
        check_output("timeout_err", 64'(er), 64'd3);
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = {$urandom, $urandom};
        @(negedge clock);
        mif.mem_rvalid = 1'b0;
        check_output("late_rvalid_idle_resp", 64'(rif.resp_valid), 64'd0);
        check_output("late_rvalid_idle_ready", 64'(rif.req_ready), 64'd1);

        // Reset in the middle of a transaction that is parked in WAIT.
        rif.req_valid = 1'b1; rif.req_addr = 64'h1008; rif.req_wen = 1'b0;
        rif.req_size = 2'd3; rif.req_unsigned = 1'b0;
        @(negedge clock);
        rif.req_valid = 1'b0;
        check_output("wait_rst_mem_valid", 64'(mif.mem_valid), 64'd1);
        mif.mem_ready = 1'b1;
        @(negedge clock);
        mif.mem_ready = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check_output("wait_rst_resp_valid", 64'(rif.resp_valid), 64'd0);
        check_output("wait_rst_mem_valid_low", 64'(mif.mem_valid), 64'd0);
        check_output("wait_rst_mem_wen", 64'(mif.mem_wen), 64'd0);
        check_output("wait_rst_mem_wstrb", 64'(mif.mem_wstrb), 64'd0);
        check_output("wait_rst_resp_rdata", rif.resp_rdata, 64'd0);
        check_output("wait_rst_resp_err", 64'(rif.resp_err), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check_output("wait_rst_req_ready", 64'(rif.req_ready), 64'd1);
        apply_stimulus(64'h1008, 1'b0, 2'd3, 1'b0, 64'd0, 0, 1, 1'b0, 1'b0, 0, rd, er);

        for (int t = 0; t < 60; t++) begin
            sz = 2'($urandom_range(0, 3));
            we = 1'($urandom);
            un = 1'($urandom);
            a  = 64'h1000 + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 4) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            wd = {$urandom, $urandom};
            ei = ($urandom_range(0, 7) == 0);
            nr = ($urandom_range(0, 15) == 0);
            apply_stimulus(a, we, sz, un, wd, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                           nr, ei, int'($urandom_range(0, 2)), rd, er);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
